// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
package alu_pkg;

    localparam int NREQ  = 2;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last time wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/fidmas.sv
// Combinational int/float add/sub/mul/div unit. Float path is IEEE single, truncating,
// without subnormal/NaN handling; int divide by zero yields quotient all-ones, remainder a.
module fidmas
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  op_e          s_i,
    input  logic         float_i,
    output logic [N-1:0] out_o,
    output logic [N-1:0] outh_o,
    output logic         car_o
);

    function automatic logic [31:0] f_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p, q;
        logic [24:0] mp, mq, m;
        logic [7:0]  e;
        if (x[30:0] >= y[30:0]) begin p = x; q = y; end
        else begin p = y; q = x; end
        mp = {1'b0, p[30:23] != 8'd0, p[22:0]};
        mq = {1'b0, q[30:23] != 8'd0, q[22:0]} >> (p[30:23] - q[30:23]);
        m  = (p[31] == q[31]) ? mp + mq : mp - mq;
        e  = p[30:23];
        if (m[24]) begin
            m = m >> 1;
            e = e + 8'd1;
        end
        for (int i = 0; i < 24; i++) begin
            if (!m[23] && m != '0) begin
                m = m << 1;
                e = e - 8'd1;
            end
        end
        return (m == '0) ? 32'd0 : {p[31], e, m[22:0]};
    endfunction

    function automatic logic [31:0] f_mul(input logic [31:0] x, input logic [31:0] y);
        logic [47:0] m;
        logic [9:0]  e;
        logic [31:0] r;
        m = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e = {2'b0, x[30:23]} + {2'b0, y[30:23]} - 10'd127;
        if (m[47]) begin
            m = m >> 1;
            e = e + 10'd1;
        end
        r = {x[31] ^ y[31], e[7:0], m[45:23]};
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) r = {x[31] ^ y[31], 31'd0};
        return r;
    endfunction

    function automatic logic [31:0] f_div(input logic [31:0] x, input logic [31:0] y);
        logic [47:0] q;
        logic [9:0]  e;
        logic [31:0] r;
        q = {1'b1, x[22:0], 24'd0} / {24'd0, 1'b1, y[22:0]};
        e = {2'b0, x[30:23]} - {2'b0, y[30:23]} + 10'd127;
        if (!q[24]) begin
            q = q << 1;
            e = e - 10'd1;
        end
        r = {x[31] ^ y[31], e[7:0], q[23:1]};
        if (y[30:23] == 8'd0)      r = {x[31] ^ y[31], 8'hFF, 23'd0};
        else if (x[30:23] == 8'd0) r = {x[31] ^ y[31], 31'd0};
        return r;
    endfunction

    logic [31:0]    fa, fb, fres;
    logic [2*N-1:0] prod;
    logic [N:0]     sum;
    logic [N-1:0]   b_add;

    assign fa    = 32'(a_i);
    assign fb    = 32'(b_i);
    assign b_add = (s_i == OP_SUB) ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_add} + {{N{1'b0}}, s_i == OP_SUB};
    assign prod  = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};

    always_comb begin
        out_o  = '0;
        outh_o = '0;
        car_o  = 1'b0;
        fres   = '0;
        if (float_i) begin
            case (s_i)
                OP_ADD:  fres = f_add(fa, fb);
                OP_SUB:  fres = f_add(fa, fb ^ 32'h8000_0000);
                OP_MUL:  fres = f_mul(fa, fb);
                default: fres = f_div(fa, fb);
            endcase
            out_o = N'(fres);
        end else begin
            case (s_i)
                OP_ADD, OP_SUB: {car_o, out_o} = sum;
                OP_MUL:         {outh_o, out_o} = prod;
                default: begin
                    if (b_i == '0) begin
                        out_o  = '1;
                        outh_o = a_i;
                    end else begin
                        out_o  = a_i / b_i;
                        outh_o = a_i % b_i;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler sharing one fidmas between two issue ports; one op in flight,
// operands held LAT cycles (multicycle window), tagged response with backpressure.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int N   = 32,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*N-1:0]    req_a,
    input  logic [2*N-1:0]    req_b,
    input  logic [3:0]        req_s,
    input  logic [NREQ-1:0]   req_float,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [N-1:0]      rsp_out,
    output logic [N-1:0]      rsp_outh,
    output logic              rsp_car,
    output logic              rsp_dz,
    output logic              busy,
    output logic [15:0]       op_count
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       a_q, a_d, b_q, b_d;
    op_e                s_q, s_d;
    logic               float_q, float_d, id_q, id_d;
    logic [N-1:0]       out_q, out_d, outh_q, outh_d;
    logic               car_q, car_d, dz_q, dz_d, vld_q, vld_d;
    logic [15:0]        cnt_ops_q, cnt_ops_d;

    logic [1:0]         grant;
    logic               win_id;
    logic [N-1:0]       alu_out, alu_outh;
    logic               alu_car;

    rr_arb2 u_arb (
        .valid_i      (req_valid),
        .last_grant_i (last_q),
        .grant_o      (grant)
    );

    fidmas #(.N(N)) u_alu (
        .a_i     (a_q),
        .b_i     (b_q),
        .s_i     (s_q),
        .float_i (float_q),
        .out_o   (alu_out),
        .outh_o  (alu_outh),
        .car_o   (alu_car)
    );

    assign win_id    = grant[1];
    assign req_ready = (state_q == IDLE) ? grant : 2'b00;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        float_d   = float_q;
        id_d      = id_q;
        out_d     = out_q;
        outh_d    = outh_q;
        car_d     = car_q;
        dz_d      = dz_q;
        vld_d     = vld_q;
        cnt_ops_d = cnt_ops_q;
        case (state_q)
            IDLE: begin
                if (|(req_valid & req_ready)) begin
                    a_d     = win_id ? req_a[2*N-1:N] : req_a[N-1:0];
                    b_d     = win_id ? req_b[2*N-1:N] : req_b[N-1:0];
                    s_d     = op_e'(win_id ? req_s[3:2] : req_s[1:0]);
                    float_d = req_float[win_id];
                    id_d    = win_id;
                    last_d  = win_id;
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    out_d   = alu_out;
                    outh_d  = alu_outh;
                    car_d   = alu_car;
                    dz_d    = !float_q && s_q == OP_DIV && b_q == '0;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    vld_d     = 1'b0;
                    cnt_ops_d = cnt_ops_q + 16'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= OP_ADD;
            float_q   <= 1'b0;
            id_q      <= 1'b0;
            out_q     <= '0;
            outh_q    <= '0;
            car_q     <= 1'b0;
            dz_q      <= 1'b0;
            vld_q     <= 1'b0;
            cnt_ops_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            float_q   <= float_d;
            id_q      <= id_d;
            out_q     <= out_d;
            outh_q    <= outh_d;
            car_q     <= car_d;
            dz_q      <= dz_d;
            vld_q     <= vld_d;
            cnt_ops_q <= cnt_ops_d;
        end
    end

    assign rsp_valid = vld_q;
    assign rsp_id    = id_q;
    assign rsp_out   = out_q;
    assign rsp_outh  = outh_q;
    assign rsp_car   = car_q;
    assign rsp_dz    = dz_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = cnt_ops_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: float/int ops, arbitration order, backpressure, reset abort.
module tb_alu_share_ctrl;

    localparam int N   = 32;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req_valid = '0;
    logic [1:0]     req_ready;
    logic [2*N-1:0] req_a = '0;
    logic [2*N-1:0] req_b = '0;
    logic [3:0]     req_s = '0;
    logic [1:0]     req_float = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic           rsp_id;
    logic [N-1:0]   rsp_out, rsp_outh;
    logic           rsp_car, rsp_dz, busy;
    logic [15:0]    op_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N:0] exp_q[$];

    alu_share_ctrl #(.N(N), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_s     (req_s),
        .req_float (req_float),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_outh  (rsp_outh),
        .rsp_car   (rsp_car),
        .rsp_dz    (rsp_dz),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int r, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [1:0] s, input logic fl);
        req_a[r*N +: N]  = a;
        req_b[r*N +: N]  = b;
        req_s[2*r +: 2]  = s;
        req_float[r]     = fl;
        req_valid[r]     = 1'b1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("rsp_timeout", 64'(rsp_valid), 64'd1);
    endtask

    // Issue one op from requester r and return cycles from accept edge to rsp_valid.
    task automatic issue(input int r, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [1:0] s, input logic fl, output int lat);
        int k;
        drive(r, a, b, s, fl);
        #1;
        k = 0;
        while (!req_ready[r] && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("accept_timeout", 64'(k < 50), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[r] = 1'b0;
        wait_rsp(lat);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    endtask

    task automatic op(input string tag, input int r, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [1:0] s, input logic fl, input logic [N-1:0] e_out,
                      input logic [N-1:0] e_outh, input logic e_car);
        int lat;
        issue(r, a, b, s, fl, lat);
        check({tag, "_lat"}, 64'(lat), 64'(LAT));
        check({tag, "_id"}, 64'(rsp_id), 64'(r));
        check({tag, "_out"}, 64'(rsp_out), 64'(e_out));
        check({tag, "_outh"}, 64'(rsp_outh), 64'(e_outh));
        check({tag, "_car"}, 64'(rsp_car), 64'(e_car));
        check({tag, "_dz"}, 64'(rsp_dz), 64'd0);
        take_rsp();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat, n, cyc;
        logic [N:0] e;
        logic [N-1:0] snap_out, snap_outh;

        do_reset();
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_rsp_out", 64'(rsp_out), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);

        op("fadd", 0, 32'h3F80_0000, 32'h4000_0000, 2'b00, 1'b1, 32'h4040_0000, 32'h0, 1'b0);
        op("iadd_c", 1, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        op("imul", 0, 32'h0001_0000, 32'h0001_0000, 2'b10, 1'b0, 32'h0, 32'h1, 1'b0);
        op("isub", 1, 32'd5, 32'd3, 2'b01, 1'b0, 32'd2, 32'h0, 1'b1);
        op("fmul", 0, 32'h4000_0000, 32'h4040_0000, 2'b10, 1'b1, 32'h40C0_0000, 32'h0, 1'b0);
        op("fdiv", 1, 32'h40C0_0000, 32'h4000_0000, 2'b11, 1'b1, 32'h4040_0000, 32'h0, 1'b0);
        op("fsub", 0, 32'h4040_0000, 32'h3F80_0000, 2'b01, 1'b1, 32'h4000_0000, 32'h0, 1'b0);
        check("op_count_7", 64'(op_count), 64'd7);

        // Both requesters valid continuously from reset: grants alternate 0,1,0,1.
        do_reset();
        exp_q.push_back({1'b0, 32'd3});
        exp_q.push_back({1'b1, 32'd50});
        exp_q.push_back({1'b0, 32'd3});
        exp_q.push_back({1'b1, 32'd50});
        drive(0, 32'd1, 32'd2, 2'b00, 1'b0);
        drive(1, 32'd20, 32'd30, 2'b00, 1'b0);
        rsp_ready = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
            if (rsp_valid) begin
                e = exp_q.pop_front();
                check("rr_id", 64'(rsp_id), 64'(e[N]));
                check("rr_out", 64'(rsp_out), 64'(e[N-1:0]));
                n++;
                if (n == 4) req_valid = 2'b00;
            end
        end
        check("rr_count_done", 64'(n), 64'd4);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        check("rr_op_count", 64'(op_count), 64'd4);

        // Divide by zero with a stalled consumer while requester 0 waits.
        issue(1, 32'd7, 32'd0, 2'b11, 1'b0, lat);
        check("dz_lat", 64'(lat), 64'(LAT));
        snap_out  = rsp_out;
        snap_outh = rsp_outh;
        drive(0, 32'd4, 32'd5, 2'b00, 1'b0);
        repeat (10) begin
            #1;
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_dz", 64'(rsp_dz), 64'd1);
            check("bp_id", 64'(rsp_id), 64'd1);
            check("bp_car", 64'(rsp_car), 64'd0);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
            check("bp_out_stable", 64'(rsp_out), 64'(snap_out));
            check("bp_outh_stable", 64'(rsp_outh), 64'(snap_outh));
            @(negedge clk);
        end
        take_rsp();
        check("bp_op_count", 64'(op_count), 64'd5);
        #1;
        check("bp_r0_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(lat);
        check("after_bp_lat", 64'(lat), 64'(LAT));
        check("after_bp_id", 64'(rsp_id), 64'd0);
        check("after_bp_out", 64'(rsp_out), 64'd9);
        take_rsp();

        // Reset mid-EXEC discards the op; requester 0 wins first afterwards.
        drive(1, 32'd11, 32'd22, 2'b00, 1'b0);
        #1;
        check("ra_ready", 64'(req_ready), 64'd2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        check("ra_busy_exec", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("ra_busy", 64'(busy), 64'd0);
        check("ra_op_count", 64'(op_count), 64'd0);
        repeat (4) begin
            check("ra_no_rsp", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        drive(0, 32'd1, 32'd1, 2'b00, 1'b0);
        drive(1, 32'd2, 32'd2, 2'b00, 1'b0);
        #1;
        check("ra_first_r0", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(lat);
        check("ra_id", 64'(rsp_id), 64'd0);
        check("ra_out", 64'(rsp_out), 64'd2);
        take_rsp();
        check("ra_op_count_1", 64'(op_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
